// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared constants for the I/D memory port arbiter
package memory_port_arbiter_pkg;

  // Arbiter FSM encodings
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_ISSUE = 2'd1;
  localparam logic [1:0] STATE_WAIT  = 2'd2;

  // Transaction owner encodings
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Byte-enable width for a given data bus width
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// rtl/memory_port_arbiter_if.sv - fetch, data and memory buses of the arbiter
// slave  : arbiter view (takes I/D requests, drives the memory request)
// master : environment view (core fetch/memory stages and main memory)
interface memory_port_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 12
);
  import memory_port_arbiter_pkg::*;

  localparam int BE_W = be_width(DATA_WIDTH);

  // Instruction-fetch side
  logic                    i_req;
  logic [ADDRESS_BITS-1:0] i_address;
  logic                    i_ready;
  logic                    i_valid;
  logic [DATA_WIDTH-1:0]   i_data;

  // Data side
  logic                    d_req;
  logic                    d_write;
  logic [BE_W-1:0]         d_byte_en;
  logic [ADDRESS_BITS-1:0] d_address;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic                    d_ready;
  logic                    d_valid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  // Main memory side
  logic                    mem_req;
  logic                    mem_write;
  logic [BE_W-1:0]         mem_byte_en;
  logic [ADDRESS_BITS-1:0] mem_address;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_ready;
  logic                    mem_valid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  logic                    err_unexpected;

  modport slave (
    input  i_req, i_address,
    output i_ready, i_valid, i_data,
    input  d_req, d_write, d_byte_en, d_address, d_wdata,
    output d_ready, d_valid, d_rdata,
    output mem_req, mem_write, mem_byte_en, mem_address, mem_wdata,
    input  mem_ready, mem_valid, mem_rdata,
    output err_unexpected
  );

  modport master (
    output i_req, i_address,
    input  i_ready, i_valid, i_data,
    output d_req, d_write, d_byte_en, d_address, d_wdata,
    input  d_ready, d_valid, d_rdata,
    input  mem_req, mem_write, mem_byte_en, mem_address, mem_wdata,
    output mem_ready, mem_valid, mem_rdata,
    input  err_unexpected
  );

endinterface

// File: rtl/memory_port_arbiter_starve_counter.sv
// rtl/memory_port_arbiter_starve_counter.sv - fetch starvation counter
// Ports: clock, reset (async active-low); grant_i/grant_d are the arbiter's
// grants this cycle, i_req the fetch request; force_i says fetch must win the
// next arbitration if it is requesting.
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic grant_i,
  input  logic grant_d,
  input  logic i_req,
  output logic force_i
);

  localparam int              CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (grant_i) begin
      count_d = '0;
    end else if (grant_d) begin
      if (!i_req) begin
        count_d = '0;
      end else if (count_q != LIMIT) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign force_i = (count_q == LIMIT);

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one single-port memory between fetch and data sides
// Ports: clock, reset (async active-low), bus (slave modport) carrying the
// I request/response, D request/response, memory request/response and the
// sticky err_unexpected flag. D normally wins; the starvation counter forces
// an I win after STARVE_LIMIT back-to-back D grants while I waits.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  memory_port_arbiter_if.slave bus
);

  localparam int BE_W = be_width(DATA_WIDTH);

  logic [1:0]              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    write_q, write_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;

  logic grant_i, grant_d, complete, force_i;

  arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clock   (clock),
    .reset   (reset),
    .grant_i (grant_i),
    .grant_d (grant_d),
    .i_req   (bus.i_req),
    .force_i (force_i)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    write_d  = write_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    complete = 1'b0;

    case (state_q)
      STATE_IDLE: begin
        // Ready pulses are combinational, so keep them low while reset is held.
        if (reset) begin
          grant_i = bus.i_req & (~bus.d_req | force_i);
          grant_d = bus.d_req & ~grant_i;
        end
        if (grant_i) begin
          owner_d = OWNER_I;
          write_d = 1'b0;
          be_d    = '1;
          addr_d  = bus.i_address;
          wdata_d = '0;
          state_d = STATE_ISSUE;
        end else if (grant_d) begin
          owner_d = OWNER_D;
          write_d = bus.d_write;
          be_d    = bus.d_write ? bus.d_byte_en : '1;
          addr_d  = bus.d_address;
          wdata_d = bus.d_write ? bus.d_wdata : '0;
          state_d = STATE_ISSUE;
        end
        if (bus.mem_valid) begin
          err_d = 1'b1;
        end
      end
      STATE_ISSUE: begin
        if (bus.mem_ready) begin
          // Same-cycle memory: accept and respond together.
          if (bus.mem_valid) begin
            complete = 1'b1;
            state_d  = STATE_IDLE;
          end else begin
            state_d  = STATE_WAIT;
          end
        end else if (bus.mem_valid) begin
          err_d = 1'b1;
        end
      end
      STATE_WAIT: begin
        if (bus.mem_valid) begin
          complete = 1'b1;
          state_d  = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= STATE_IDLE;
      owner_q <= OWNER_I;
      write_q <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Memory request fields are gated so the bus reads all-zero when idle.
  assign bus.mem_req     = (state_q == STATE_ISSUE);
  assign bus.mem_write   = bus.mem_req & write_q;
  assign bus.mem_byte_en = bus.mem_req ? be_q    : '0;
  assign bus.mem_address = bus.mem_req ? addr_q  : '0;
  assign bus.mem_wdata   = bus.mem_req ? wdata_q : '0;

  assign bus.i_ready = grant_i;
  assign bus.d_ready = grant_d;
  assign bus.i_valid = complete & (owner_q == OWNER_I);
  assign bus.d_valid = complete & (owner_q == OWNER_D);
  assign bus.i_data  = bus.i_valid ? bus.mem_rdata : '0;
  assign bus.d_rdata = bus.d_valid ? bus.mem_rdata : '0;

  assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  memory_port_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_BITS(12)) bus ();

  memory_port_arbiter #(
    .DATA_WIDTH   (32),
    .ADDRESS_BITS (12),
    .STARVE_LIMIT (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        same;
    logic        exp_wr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    logic        chk_data;
  } sb_t;

  int   checks   = 0;
  int   failures = 0;
  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vecs[6];
  bit   exp_i[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return {bus.i_ready, bus.i_valid, bus.i_data, bus.d_ready, bus.d_valid, bus.d_rdata,
            bus.mem_req, bus.mem_write, bus.mem_byte_en, bus.mem_address, bus.mem_wdata,
            bus.err_unexpected};
  endfunction

  // Scoreboard monitor: every valid pulse must match the oldest outstanding grant.
  always @(negedge clock) begin
    if (bus.i_valid || bus.d_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual i=%b d=%b required none", bus.i_valid, bus.d_valid);
      end else begin
        mon_e = sb.pop_front();
        check("valid_owner", {bus.i_valid, bus.d_valid}, mon_e.owner ? 2'b01 : 2'b10);
        if (mon_e.chk_data)
          check("valid_data", mon_e.owner ? bus.d_rdata : bus.i_data, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    tick();
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_write = v.wr; bus.d_byte_en = v.be;
      bus.d_address = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_address = v.addr;
    end
    #1;
    check("grant_ready", v.is_d ? bus.d_ready : bus.i_ready, 1'b1);
    check("other_ready", v.is_d ? bus.i_ready : bus.d_ready, 1'b0);
    sb.push_back('{owner: v.is_d, data: v.rdata, chk_data: !(v.is_d && v.wr)});
    tick();
    // Scramble request fields after capture to prove they were registered.
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    bus.i_address = ~v.addr; bus.d_address = ~v.addr; bus.d_wdata = ~v.wdata;
    bus.d_byte_en = ~v.be; bus.d_write = ~v.wr;
    for (int n = 0; n <= v.lat; n++) begin
      if (n > 0) tick();
      bus.mem_ready = (n == v.lat);
      bus.mem_valid = (n == v.lat) && v.same;
      bus.mem_rdata = v.rdata;
      #1;
      check("mem_fields", {bus.mem_req, bus.mem_write, bus.mem_byte_en, bus.mem_address, bus.mem_wdata},
            {1'b1, v.exp_wr, v.exp_be, v.addr, v.exp_wdata});
    end
    if (!v.same) begin
      tick();
      bus.mem_ready = 1'b0; bus.mem_valid = 1'b1; bus.mem_rdata = v.rdata;
      #1;
      check("wait_no_req", bus.mem_req, 1'b0);
    end
    tick();
    bus.mem_ready = 1'b0; bus.mem_valid = 1'b0; bus.mem_rdata = '0;
    #1;
    check("txn_done", sb.size(), 0);
    check("idle_no_req", bus.mem_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int g;
    bus.i_req = 0; bus.i_address = '0; bus.d_req = 0; bus.d_write = 0;
    bus.d_byte_en = '0; bus.d_address = '0; bus.d_wdata = '0;
    bus.mem_ready = 0; bus.mem_valid = 0; bus.mem_rdata = '0;

    //          is_d  wr    be     addr     wdata         rdata         lat same  exp_wr exp_be exp_wdata
    vecs[0] = '{1'b0, 1'b0, 4'h0, 12'h010, 32'h0,        32'h00000013, 0, 1'b0, 1'b0, 4'hF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 12'h020, 32'h00008000, 32'hDEADBEEF, 0, 1'b1, 1'b1, 4'h3, 32'h00008000};
    vecs[2] = '{1'b1, 1'b0, 4'h3, 12'h020, 32'h00001234, 32'h00008000, 1, 1'b0, 1'b0, 4'hF, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 4'hC, 12'h3FF, 32'hABCD0000, 32'h0,        5, 1'b1, 1'b1, 4'hC, 32'hABCD0000};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 12'hFFF, 32'h0,        32'hFFFFFFFF, 2, 1'b1, 1'b0, 4'hF, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 4'hF, 12'h000, 32'h00000001, 32'h0,        0, 1'b0, 1'b1, 4'hF, 32'h00000001};
    exp_i = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", all_outputs(), '0);
    reset = 1'b1;

    // Table-driven single transactions
    for (int k = 0; k < 6; k++) run_txn(vecs[k]);

    // Simultaneous requests with count 0: D first, then I in the next IDLE
    tick();
    bus.i_req = 1; bus.i_address = 12'h060;
    bus.d_req = 1; bus.d_write = 0; bus.d_address = 12'h040;
    #1;
    check("both_d_ready", {bus.i_ready, bus.d_ready}, 2'b01);
    sb.push_back('{owner: 1'b1, data: 32'h00000044, chk_data: 1'b1});
    tick();
    bus.d_req = 0;
    bus.mem_ready = 1; bus.mem_valid = 1; bus.mem_rdata = 32'h00000044;
    #1;
    check("issue_no_grant", {bus.i_ready, bus.d_ready}, 2'b00);
    check("both_d_addr", bus.mem_address, 12'h040);
    tick();
    bus.mem_ready = 0; bus.mem_valid = 0;
    #1;
    check("both_i_ready", {bus.i_ready, bus.d_ready}, 2'b10);
    sb.push_back('{owner: 1'b0, data: 32'h00000055, chk_data: 1'b1});
    tick();
    bus.i_req = 0;
    bus.mem_ready = 1; bus.mem_valid = 1; bus.mem_rdata = 32'h00000055;
    #1;
    check("both_i_addr", bus.mem_address, 12'h060);
    tick();
    bus.mem_ready = 0; bus.mem_valid = 0;

    // Continuous I and D pressure: D x4 then a forced I, repeated
    g = 0;
    for (int c = 0; c < 40 && g < 10; c++) begin
      tick();
      bus.i_req = 1; bus.d_req = 1; bus.d_write = 0;
      bus.mem_ready = bus.mem_req; bus.mem_valid = bus.mem_req; bus.mem_rdata = 32'h0BADF00D;
      #1;
      if (bus.i_ready || bus.d_ready) begin
        check("starve_grant", {bus.i_ready, bus.d_ready}, exp_i[g] ? 2'b10 : 2'b01);
        sb.push_back('{owner: ~bus.i_ready, data: 32'h0BADF00D, chk_data: 1'b1});
        g++;
      end
    end
    check("starve_grants_seen", g, 10);
    tick();
    bus.i_req = 0; bus.d_req = 0;
    bus.mem_ready = bus.mem_req; bus.mem_valid = bus.mem_req;
    tick();
    bus.mem_ready = 0; bus.mem_valid = 0;
    #1;
    check("starve_drained", sb.size(), 0);
    check("err_clear_so_far", bus.err_unexpected, 1'b0);

    // Reset during WAIT, then a late response
    tick();
    bus.i_req = 1; bus.i_address = 12'h070;
    #1;
    check("abort_grant", bus.i_ready, 1'b1);
    tick();
    bus.i_req = 0; bus.mem_ready = 1;
    #1;
    check("abort_issue", bus.mem_req, 1'b1);
    tick();
    bus.mem_ready = 0;
    sb.delete();
    reset = 1'b0;
    #1;
    check("reset_mid_wait", all_outputs(), '0);
    tick();
    reset = 1'b1;
    tick();
    bus.mem_valid = 1; bus.mem_rdata = 32'h00000077;
    #1;
    check("late_no_valid", {bus.i_valid, bus.d_valid}, 2'b00);
    tick();
    bus.mem_valid = 0;
    #1;
    check("err_set", bus.err_unexpected, 1'b1);
    repeat (3) tick();
    check("err_sticky", {bus.err_unexpected, bus.mem_req}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
